// File: rtl/wb_host_if.sv
// Wishbone slave bridging a host bus to the ASCON shared memory and engine control/status registers.
// Optional build macro WB_BUSY_ERR_EN: memory accesses while the engine is busy end in an error instead of waiting.
module wb_host_if (
  input  logic        clk,
  input  logic        RST,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  input  logic        busy,
  input  logic [31:0] mem_dataout,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] datain_wb,
  output logic        start,
  output logic [7:0]  datalen
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned LW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_ACK,
    S_HOLD,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          start_q, start_d;
  logic [LW-1:0] datalen_q, datalen_d;
  logic          done_q, done_d;
  logic          busy_q;

  logic          req;
  logic          mem_sel;
  logic [AW-1:0] word;
  logic          reg_ctrl;
  logic          reg_status;
  logic [DW-1:0] reg_rdata;
  logic          stat_rd;
  logic          mem_issue;
  logic          unused_adr;

  assign req        = wbs_cyc_i & wbs_stb_i;
  assign mem_sel    = ~wbs_adr_i[7];
  assign word       = wbs_adr_i[6:2];
  assign reg_ctrl   = (word == AW'(0));
  assign reg_status = (word == AW'(1));
  assign unused_adr = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

  // Register read mux; unmapped register words read as zero.
  always_comb begin
    reg_rdata = '0;
    if (reg_ctrl)        reg_rdata = {16'h0, datalen_q, 8'h0};
    else if (reg_status) reg_rdata = {30'h0, done_q, busy};
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= S_IDLE;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      we_q      <= 1'b1;
      addr_q    <= '0;
      din_q     <= '0;
      start_q   <= 1'b0;
      datalen_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      start_q   <= start_d;
      datalen_q <= datalen_d;
      done_q    <= done_d;
      busy_q    <= busy;
    end
  end

  // Engine-finished flag: a falling busy edge beats a same-cycle STATUS read clear.
  always_comb begin
    done_d = (busy_q & ~busy) | (done_q & ~stat_rd);
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    dat_d     = '0;
    we_d      = 1'b1;
    addr_d    = '0;
    din_d     = '0;
    start_d   = 1'b0;
    datalen_d = datalen_q;
    stat_rd   = 1'b0;
    mem_issue = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (!mem_sel) begin
            state_d = S_ACK;
            ack_d   = 1'b1;
            if (wbs_we_i) begin
              if (reg_ctrl) begin
                datalen_d = wbs_dat_i[15:8];
                start_d   = wbs_dat_i[0] & ~busy;
              end
            end else begin
              dat_d   = reg_rdata;
              stat_rd = reg_status;
            end
          end else if (busy) begin
`ifdef WB_BUSY_ERR_EN
            state_d = S_ERR;
            err_d   = 1'b1;
`else
            state_d = S_HOLD;
`endif
          end else begin
            mem_issue = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (!wbs_cyc_i)  state_d   = S_IDLE;
        else if (!busy)  mem_issue = 1'b1;
      end
      S_RD_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          dat_d   = mem_dataout;
        end
      end
      S_ACK:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Launch the memory-side cycle; an all-zero byte select acks without writing.
    if (mem_issue) begin
      if (wbs_we_i) begin
        state_d = S_ACK;
        ack_d   = 1'b1;
        if (|wbs_sel_i) begin
          we_d   = 1'b0;
          addr_d = word;
          din_d  = wbs_dat_i;
        end
      end else begin
        state_d = S_RD_WAIT;
        addr_d  = word;
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign wb_we     = we_q;
  assign wb_addr   = addr_q;
  assign datain_wb = din_q;
  assign start     = start_q;
  assign datalen   = datalen_q;
`ifdef WB_BUSY_ERR_EN
  assign wbs_err_o = err_q;
`else
  assign wbs_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_host_if.sv
// Directed self-checking bench for wb_host_if with a small shared-memory model.
`timescale 1ns/1ps
module tb_wb_host_if;

  logic        clk = 1'b0;
  logic        RST;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o;
  logic        busy;
  logic [31:0] mem_dataout;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] datain_wb;
  logic        start;
  logic [7:0]  datalen;

  logic [31:0] mem [0:31];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_host_if dut (
    .clk(clk), .RST(RST),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .busy(busy), .mem_dataout(mem_dataout),
    .wb_we(wb_we), .wb_addr(wb_addr), .datain_wb(datain_wb),
    .start(start), .datalen(datalen)
  );

  // Shared memory: word i resets to C0DE_0000+i, read data follows the presented address.
  always @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
    end else if (!wb_we) begin
      mem[wb_addr] <= datain_wb;
    end
  end
  assign mem_dataout = mem[wb_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_req(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
  endtask

  task automatic bus_idle();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
  endtask

  initial begin
    RST = 1'b1; busy = 1'b0;
    bus_idle();
    tick(); tick();
    chk("rst_ack", 32'(wbs_ack_o), 32'h0);
    chk("rst_err", 32'(wbs_err_o), 32'h0);
    chk("rst_dat", wbs_dat_o, 32'h0);
    chk("rst_start", 32'(start), 32'h0);
    chk("rst_datalen", 32'(datalen), 32'h0);
    chk("rst_we", 32'(wb_we), 32'h1);
    chk("rst_addr", 32'(wb_addr), 32'h0);
    chk("rst_din", datain_wb, 32'h0);
    RST = 1'b0;
    tick();

    // Memory write then read of word 3
    bus_req(32'h0C, 1'b1, 32'h0000_00A5, 4'hF);
    tick();
    chk("mw_ack", 32'(wbs_ack_o), 32'h1);
    chk("mw_we", 32'(wb_we), 32'h0);
    chk("mw_addr", 32'(wb_addr), 32'h3);
    chk("mw_din", datain_wb, 32'h0000_00A5);
    bus_idle();
    tick();
    chk("mw_ack_end", 32'(wbs_ack_o), 32'h0);
    chk("mw_we_end", 32'(wb_we), 32'h1);
    chk("mw_din_end", datain_wb, 32'h0);
    bus_req(32'h0C, 1'b0, 32'h0, 4'hF);
    tick();
    chk("mr_wait_ack", 32'(wbs_ack_o), 32'h0);
    chk("mr_wait_addr", 32'(wb_addr), 32'h3);
    chk("mr_wait_we", 32'(wb_we), 32'h1);
    tick();
    chk("mr_ack", 32'(wbs_ack_o), 32'h1);
    chk("mr_dat", wbs_dat_o, 32'h0000_00A5);
    bus_idle();
    tick();
    chk("mr_ack_end", 32'(wbs_ack_o), 32'h0);

    // CTRL write with start, then readback
    bus_req(32'h80, 1'b1, 32'h0000_2301, 4'hF);
    tick();
    chk("ctrl_ack", 32'(wbs_ack_o), 32'h1);
    chk("ctrl_start", 32'(start), 32'h1);
    chk("ctrl_datalen", 32'(datalen), 32'h23);
    bus_idle();
    tick();
    chk("ctrl_start_end", 32'(start), 32'h0);
    tick();
    chk("ctrl_start_end2", 32'(start), 32'h0);
    bus_req(32'h80, 1'b0, 32'h0, 4'hF);
    tick();
    chk("ctrl_rd_ack", 32'(wbs_ack_o), 32'h1);
    chk("ctrl_rd", wbs_dat_o, 32'h0000_2300);
    bus_idle();
    tick();

    // Start request while busy is dropped; register access still acks immediately
    busy = 1'b1;
    bus_req(32'h80, 1'b1, 32'h0000_4501, 4'hF);
    tick();
    chk("ctrl_busy_ack", 32'(wbs_ack_o), 32'h1);
    chk("ctrl_busy_start", 32'(start), 32'h0);
    chk("ctrl_busy_datalen", 32'(datalen), 32'h45);
    bus_idle();
    tick();
    chk("ctrl_busy_start2", 32'(start), 32'h0);

    // busy falls, then two STATUS reads
    busy = 1'b0;
    tick();
    bus_req(32'h84, 1'b0, 32'h0, 4'hF);
    tick();
    chk("stat1_ack", 32'(wbs_ack_o), 32'h1);
    chk("stat1", wbs_dat_o, 32'h0000_0002);
    bus_idle();
    tick();
    bus_req(32'h84, 1'b0, 32'h0, 4'hF);
    tick();
    chk("stat2", wbs_dat_o, 32'h0000_0000);
    bus_idle();
    tick();

    // Falling edge coincides with a STATUS read: set wins
    busy = 1'b1;
    tick();
    busy = 1'b0;
    bus_req(32'h84, 1'b0, 32'h0, 4'hF);
    tick();
    chk("stat_same_cyc", wbs_dat_o, 32'h0000_0000);
    bus_idle();
    tick();
    bus_req(32'h84, 1'b0, 32'h0, 4'hF);
    tick();
    chk("stat_after_same", wbs_dat_o, 32'h0000_0002);
    bus_idle();
    tick();

    // Unmapped register: reads zero, write ignored, both ack
    bus_req(32'h88, 1'b0, 32'h0, 4'hF);
    tick();
    chk("unmap_rd_ack", 32'(wbs_ack_o), 32'h1);
    chk("unmap_rd", wbs_dat_o, 32'h0);
    bus_idle();
    tick();
    bus_req(32'h88, 1'b1, 32'hFFFF_FFFF, 4'hF);
    tick();
    chk("unmap_wr_ack", 32'(wbs_ack_o), 32'h1);
    chk("unmap_wr_datalen", 32'(datalen), 32'h45);
    chk("unmap_wr_start", 32'(start), 32'h0);
    bus_idle();
    tick();

    // sel=0 write acks without touching memory
    bus_req(32'h14, 1'b1, 32'hDEAD_BEEF, 4'h0);
    tick();
    chk("sel0_ack", 32'(wbs_ack_o), 32'h1);
    chk("sel0_we", 32'(wb_we), 32'h1);
    bus_idle();
    tick();
    bus_req(32'h14, 1'b0, 32'h0, 4'hF);
    tick(); tick();
    chk("sel0_rd", wbs_dat_o, 32'hC0DE_0005);
    bus_idle();
    tick();

`ifdef WB_BUSY_ERR_EN
    // Busy memory read errors out
    busy = 1'b1;
    bus_req(32'h10, 1'b0, 32'h0, 4'hF);
    tick();
    chk("berr_err", 32'(wbs_err_o), 32'h1);
    chk("berr_ack", 32'(wbs_ack_o), 32'h0);
    chk("berr_addr", 32'(wb_addr), 32'h0);
    bus_idle();
    tick();
    chk("berr_err_end", 32'(wbs_err_o), 32'h0);
    chk("berr_ack_end", 32'(wbs_ack_o), 32'h0);
    busy = 1'b0;
    tick();
`else
    // Busy memory read holds until busy drops
    busy = 1'b1;
    bus_req(32'h10, 1'b0, 32'h0, 4'hF);
    tick();
    chk("hold_ack", 32'(wbs_ack_o), 32'h0);
    chk("hold_we", 32'(wb_we), 32'h1);
    chk("hold_addr", 32'(wb_addr), 32'h0);
    tick(); tick();
    chk("hold_ack2", 32'(wbs_ack_o), 32'h0);
    chk("hold_err", 32'(wbs_err_o), 32'h0);
    busy = 1'b0;
    tick();
    chk("hold_rd_addr", 32'(wb_addr), 32'h4);
    chk("hold_rd_ack", 32'(wbs_ack_o), 32'h0);
    tick();
    chk("hold_done_ack", 32'(wbs_ack_o), 32'h1);
    chk("hold_done_dat", wbs_dat_o, 32'hC0DE_0004);
    bus_idle();
    tick();

    // cyc dropped while held: no ack, no write
    busy = 1'b1;
    bus_req(32'h18, 1'b1, 32'h1234_5678, 4'hF);
    tick();
    chk("abort_hold_we", 32'(wb_we), 32'h1);
    bus_idle();
    tick();
    busy = 1'b0;
    tick();
    chk("abort_ack", 32'(wbs_ack_o), 32'h0);
    chk("abort_we", 32'(wb_we), 32'h1);
    bus_req(32'h18, 1'b0, 32'h0, 4'hF);
    tick(); tick();
    chk("abort_rd", wbs_dat_o, 32'hC0DE_0006);
    bus_idle();
    tick();
`endif

    // Reset during RD_WAIT aborts the read
    bus_req(32'h80, 1'b1, 32'h0000_7700, 4'hF);
    tick();
    bus_idle();
    tick();
    bus_req(32'h08, 1'b0, 32'h0, 4'hF);
    tick();
    chk("rrst_wait_addr", 32'(wb_addr), 32'h2);
    RST = 1'b1;
    tick();
    bus_idle();
    chk("rrst_ack", 32'(wbs_ack_o), 32'h0);
    chk("rrst_dat", wbs_dat_o, 32'h0);
    chk("rrst_addr", 32'(wb_addr), 32'h0);
    chk("rrst_we", 32'(wb_we), 32'h1);
    chk("rrst_datalen", 32'(datalen), 32'h0);
    RST = 1'b0;
    tick();
    chk("rrst_ack_after", 32'(wbs_ack_o), 32'h0);
    bus_req(32'h84, 1'b0, 32'h0, 4'hF);
    tick();
    chk("rrst_status", wbs_dat_o, 32'h0);
    bus_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
